// File: rtl/heater_pkg.sv
// Shared types and constants for the heater lane error monitor.
// The SETTLE default matches the lane delay/check pipeline depth, so the
// blanking window covers the worst-case refill of every lane.
package heater_pkg;

  // Monitor sequencing states.
  typedef enum logic [1:0] {
    CLEARING = 2'd0,
    SETTLE   = 2'd1,
    ARMED    = 2'd2
  } state_t;

  // Blanking length shared with the lane pipeline depth.
  localparam int SETTLE_CYCLES_DEFAULT = 8192;

  // Index width for n items. It is never below 1, so a single-lane build
  // still has a legal one-bit index bus.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/heater_prio_enc.sv
// Lowest-set-bit priority encoder.
// Lane 0 has the highest priority. When several lanes fail in the same
// cycle, the lowest index is reported as the first failing lane.
module heater_prio_enc
  import heater_pkg::*;
#(
  parameter  int N_LANES = 16,
  localparam int IDX_W   = idx_w(N_LANES)
) (
  input  logic [N_LANES-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan from the top down so that the last (lowest) set bit wins.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/heater_err_monitor.sv
// Heater lane error monitor.
// Drives err_clear to the lane checkers and then blanks their error outputs
// while the pipelines refill. After that it arms. While armed it latches
// sticky per-lane flags, records the first failing lane, counts error cycles
// (saturating) and raises one alarm.
//
// The lane errors are registered once into err_q. Every status update uses
// err_q, so a lane error seen before edge k reaches the status outputs at
// edge k+1.
// clear_req works in any state. It restarts the clear/settle sequence and
// wipes all status, and it takes priority over any error in the same cycle.
// The state output is a debug view of the sequencer.
module heater_err_monitor
  import heater_pkg::*;
#(
  parameter  int N_LANES       = 16,
  parameter  int CLR_CYCLES    = 4,
  parameter  int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter  int CNT_W         = 16,
  localparam int IDX_W         = idx_w(N_LANES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LANES-1:0] lane_error,
  input  logic               clear_req,
  output logic               err_clear,
  output logic               armed,
  output logic [N_LANES-1:0] sticky_err,
  output logic               first_valid,
  output logic [IDX_W-1:0]   first_lane,
  output logic [CNT_W-1:0]   err_count,
  output logic               alarm,
  output state_t             state
);

  // The phase counter is shared by CLEARING and SETTLE, so it is sized for
  // the longer of the two.
  localparam int PH_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = idx_w(PH_MAX);

  localparam logic [PH_W-1:0]  CLR_LAST    = PH_W'(CLR_CYCLES - 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic [PH_W-1:0]    phase;
  logic [N_LANES-1:0] err_q;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;

  // Register the lane errors every cycle so the status logic never sees
  // raw, unsynchronised lane outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= lane_error;
    end
  end

  // Lowest failing lane in this cycle's registered error vector.
  heater_prio_enc #(
    .N_LANES (N_LANES)
  ) u_prio_enc (
    .vec   (err_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Sequencer: hold clear for CLR_CYCLES, blank for SETTLE_CYCLES, then arm.
  // A clear request restarts the sequence from the beginning.
  always_ff @(posedge clk) begin
    if (reset || clear_req) begin
      state     <= CLEARING;
      phase     <= '0;
      err_clear <= 1'b1;
      armed     <= 1'b0;
    end else begin
      case (state)
        CLEARING: begin
          if (phase == CLR_LAST) begin
            state     <= SETTLE;
            phase     <= '0;
            err_clear <= 1'b0;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        SETTLE: begin
          if (phase == SETTLE_LAST) begin
            state <= ARMED;
            phase <= '0;
            armed <= 1'b1;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        ARMED: begin
          phase <= '0;
        end
        default: begin
          state     <= CLEARING;
          phase     <= '0;
          err_clear <= 1'b1;
          armed     <= 1'b0;
        end
      endcase
    end
  end

  // Status capture while armed. Outside ARMED every status output holds its
  // value, unless a clear or reset wipes it.
  always_ff @(posedge clk) begin
    if (reset || clear_req) begin
      sticky_err  <= '0;
      first_valid <= 1'b0;
      first_lane  <= '0;
      err_count   <= '0;
      alarm       <= 1'b0;
    end else if (state == ARMED) begin
      sticky_err <= sticky_err | err_q;
      // The first failing lane is recorded once and then frozen.
      if (!first_valid && enc_valid) begin
        first_lane  <= enc_idx;
        first_valid <= 1'b1;
      end
      // The counter saturates at full scale and does not wrap.
      if (|err_q && (err_count != CNT_MAX)) begin
        err_count <= err_count + CNT_W'(1);
      end
      // The alarm follows the new sticky value, so it rises on the same edge
      // as the sticky bit.
      alarm <= |(sticky_err | err_q);
    end
  end

endmodule

// File: doc/heater_err_monitor.md
Name: heater_err_monitor

Overview:
Sits directly downstream of the lane-level delay/check chains. Each chain's `error` output feeds this block.
It sequences the lanes' `err_clear` after reset or on request, and blanks errors while the pipelines refill. Once armed, it latches per-lane sticky error flags, captures the first failing lane, counts error cycles, and drives a single alarm to the status/LED logic.

Parameters:
N_LANES, 16, number of lane error inputs (1..64)
CLR_CYCLES, 4, cycles err_clear is held high per clear sequence (>=1)
SETTLE_CYCLES, 8192, blanking cycles after err_clear drops; must exceed the worst lane fill latency (>=1)
CNT_W, 16, width of the saturating error-cycle counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
lane_error  in  N_LANES  per-lane error level from the lane checkers
clear_req  in  1  single-cycle request to restart the clear/settle sequence
err_clear  out  1  clear to all lane checkers (fan-out)
armed  out  1  high while in ARMED state
sticky_err  out  N_LANES  per-lane latched error flags
first_valid  out  1  first_lane holds a captured lane
first_lane  out  $clog2(N_LANES) (min 1)  index of first failing lane
err_count  out  CNT_W  cycles (ARMED) with any registered lane error; saturating
alarm  out  1  registered OR of sticky_err

Behaviour:
- Clock is clk; reset is synchronous and active-high. All state updates occur on the posedge of clk.
- Reset values:
  - state=CLEARING, err_clear=1, armed=0
  - sticky_err=0, first_valid=0, first_lane=0
  - err_count=0, alarm=0
  - phase counter=0, lane_error register=0
- Input stage: lane_error is registered once into err_q every cycle, regardless of state.
- FSM (held in one phase counter, width sized to max(CLR_CYCLES, SETTLE_CYCLES)):
  - CLEARING: err_clear=1. Counts CLR_CYCLES cycles, then moves to SETTLE with the counter at 0. err_clear is high for exactly CLR_CYCLES cycles after the reset release edge.
  - SETTLE: err_clear=0. err_q is ignored. Counts SETTLE_CYCLES cycles, then moves to ARMED.
  - ARMED: armed=1. err_q is processed. Stays here until clear_req or reset.
- clear_req in any state, on the next edge:
  - Enter CLEARING with counter 0 and err_clear=1.
  - Clear sticky_err, first_valid, first_lane, err_count and alarm.
  - clear_req during CLEARING restarts the CLR_CYCLES count.
  - clear_req in the same cycle as an ARMED error: the clear wins and no flag is set.
- ARMED processing, per edge:
  - sticky_err <= sticky_err | err_q.
  - If first_valid==0 and err_q!=0: first_lane <= lowest set index of err_q; first_valid <= 1. This is evaluated in the same cycle, so simultaneous errors resolve to the lowest index.
  - Once first_valid is set, first_lane never changes until clear/reset.
  - err_count increments when |err_q, and saturates at 2^CNT_W-1 (no wrap).
  - alarm <= |(sticky_err | err_q), so alarm rises on the same edge as the sticky bit.
- Latency: lane_error high before edge k gives err_q at edge k, and sticky_err, alarm and err_count updated at edge k+1.
- Errors present at the last SETTLE cycle are not counted. The first ARMED cycle processes err_q captured on the SETTLE→ARMED edge.
- Outputs hold their values outside ARMED except when cleared. No X propagation from an undriven lane_error after reset.

Decomposition:
- Shared package heater_pkg holds:
  - the typedef enum for states {CLEARING, SETTLE, ARMED}
  - a localparam function for the index width (clog2 with min 1)
  - the default SETTLE_CYCLES constant shared with the lane pipeline depth
- The lowest-set-bit priority encoder is a natural sub-module: heater_prio_enc, parameterised on N_LANES, outputs index and valid.

Test Plan:
- Reset release, lane_error=0, CLR_CYCLES=4, SETTLE_CYCLES=16 -> err_clear high 4 cycles; armed rises at cycle 20; all status outputs stay 0.
- Lane 5 error pulsed 1 cycle during SETTLE, then lane 5 pulsed 1 cycle in ARMED -> SETTLE pulse is ignored. The ARMED pulse gives sticky_err=0x0020, first_lane=5, first_valid=1, err_count=1, and alarm at the pulse edge+2.
- Lanes 9 and 3 asserted together in ARMED, then lane 1 later -> first_lane=3 and stays 3; sticky_err=0x020A.
- CNT_W=4, lane 0 held high 20 ARMED cycles -> err_count saturates at 15, no wrap.
- clear_req in ARMED with sticky bits set and lane 2 error in the same cycle -> next edge all status=0 and err_clear=1 for 4 cycles. No flag is set from that error.
- Reset asserted mid-SETTLE -> next edge state CLEARING with err_clear=1 and counters 0, matching the reset values.
